// File: rtl/report_pkg.sv
// Shared types and constants for the solver result reporter.
package report_pkg;

  typedef enum logic [1:0] {IDLE, CONVERT, EMIT, HALT} report_state_t;
  typedef enum logic [1:0] {ST_OK, ST_ERR, ST_TO} report_status_t;
  typedef enum logic [2:0] {PH_D, PH_TENS, PH_ONES, PH_SEP, PH_DIG, PH_LF, PH_END} emit_phase_t;

  localparam logic [7:0] CH_D  = 8'h44;
  localparam logic [7:0] CH_EQ = 8'h3D;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_T  = 8'h54;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_0  = 8'h30;

  // ceil(width * log10(2)) in fixed point; exact for every width up to 64
  function automatic int unsigned min_digits(input int unsigned width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Iterative double-dabble: one answer bit per cycle, Ready once all ANSWER_W bits are shifted in.
module bin2bcd #(
  parameter int unsigned ANSWER_W = 64,
  parameter int unsigned DIGITS   = 20
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  input  logic [ANSWER_W-1:0]   Bin,
  output logic [DIGITS*4-1:0]   Bcd,
  output logic                  Ready
);

  localparam int unsigned CNT_W = $clog2(ANSWER_W + 1);
  localparam int unsigned BCD_W = DIGITS * 4;

  logic [ANSWER_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic [BCD_W-1:0]    adj_c;

  always_comb begin
    adj_c   = bcd_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    if (Start) begin
      bin_d   = Bin;
      bcd_d   = '0;
      cnt_d   = CNT_W'(ANSWER_W);
      ready_d = 1'b0;
    end else if (cnt_q != '0) begin
      {bcd_d, bin_d} = {adj_c, bin_q} << 1;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) ready_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign Bcd   = bcd_q;
  assign Ready = ready_q;

endmodule

// File: rtl/result_reporter.sv
// Watches the solver flags, runs a watchdog, and streams one ASCII report line over valid/ready.
module result_reporter
  import report_pkg::*;
#(
  parameter int unsigned ANSWER_W       = 64,
  parameter int unsigned DIGITS         = 20,
  parameter int unsigned DAY_ID         = 1,
  parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Done,
  input  logic                Error,
  input  logic [ANSWER_W-1:0] Answer,
  output logic [7:0]          TxData,
  output logic                TxValid,
  input  logic                TxReady,
  output logic                Busy,
  output logic                Finished,
  output logic                TimedOut
);

  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned DIG_W = $clog2(DIGITS + 1);
  localparam logic [7:0]  DAY_TENS = CH_0 + 8'(DAY_ID / 10);
  localparam logic [7:0]  DAY_ONES = CH_0 + 8'(DAY_ID % 10);

  if (DIGITS < min_digits(ANSWER_W)) begin : g_digits_chk
    $error("result_reporter: DIGITS too small for ANSWER_W");
  end
  if (DAY_ID > 99) begin : g_day_chk
    $error("result_reporter: DAY_ID must be 0..99");
  end

  report_state_t       state_q, state_d;
  report_status_t      status_q, status_d;
  emit_phase_t         ph_q, ph_d;
  logic [DIG_W-1:0]    dig_q, dig_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                busy_q, busy_d;
  logic                finished_q, finished_d;
  logic                timed_out_q, timed_out_d;

  logic                start_c;
  logic                b2b_ready;
  logic [DIGITS*4-1:0] b2b_bcd;
  logic [DIG_W-1:0]    msd_c;
  logic [3:0]          nib_c;

  bin2bcd #(.ANSWER_W(ANSWER_W), .DIGITS(DIGITS)) u_bin2bcd (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Start (start_c),
    .Bin   (Answer),
    .Bcd   (b2b_bcd),
    .Ready (b2b_ready)
  );

  // Most significant non-zero digit; an all-zero answer still prints one '0'
  always_comb begin
    msd_c = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (b2b_bcd[4*i +: 4] != 4'd0) msd_c = DIG_W'(i);
    end
    nib_c = 4'(b2b_bcd >> {dig_q, 2'b00});
  end

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    ph_d        = ph_q;
    dig_d       = dig_q;
    wd_d        = wd_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    busy_d      = busy_q;
    finished_d  = finished_q;
    timed_out_d = timed_out_q;
    start_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        wd_d = (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) ? wd_q : wd_q + WD_W'(1);
        if (Error) begin
          state_d  = EMIT;
          status_d = ST_ERR;
          ph_d     = PH_D;
          busy_d   = 1'b1;
        end else if (Done) begin
          state_d  = CONVERT;
          status_d = ST_OK;
          start_c  = 1'b1;
          busy_d   = 1'b1;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 2)) begin
          state_d     = EMIT;
          status_d    = ST_TO;
          ph_d        = PH_D;
          busy_d      = 1'b1;
          timed_out_d = 1'b1;
        end
      end
      CONVERT: begin
        // 'D' is loaded straight out of CONVERT so the OK path has no idle cycle
        if (b2b_ready) begin
          state_d    = EMIT;
          tx_valid_d = 1'b1;
          tx_data_d  = CH_D;
          ph_d       = PH_TENS;
          dig_d      = msd_c;
        end
      end
      EMIT: begin
        if (!tx_valid_q || TxReady) begin
          tx_valid_d = 1'b1;
          unique case (ph_q)
            PH_D:    begin tx_data_d = CH_D;     ph_d = PH_TENS; end
            PH_TENS: begin tx_data_d = DAY_TENS; ph_d = PH_ONES; end
            PH_ONES: begin tx_data_d = DAY_ONES; ph_d = PH_SEP;  end
            PH_SEP: begin
              tx_data_d = (status_q == ST_OK)  ? CH_EQ :
                          (status_q == ST_ERR) ? CH_E  : CH_T;
              ph_d      = (status_q == ST_OK)  ? PH_DIG : PH_LF;
            end
            PH_DIG: begin
              tx_data_d = CH_0 + {4'd0, nib_c};
              if (dig_q == '0) ph_d = PH_LF;
              else             dig_d = dig_q - DIG_W'(1);
            end
            PH_LF:   begin tx_data_d = CH_LF;    ph_d = PH_END;  end
            default: begin
              tx_valid_d = 1'b0;
              busy_d     = 1'b0;
              finished_d = 1'b1;
              state_d    = HALT;
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      status_q    <= ST_OK;
      ph_q        <= PH_D;
      dig_q       <= '0;
      wd_q        <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      ph_q        <= ph_d;
      dig_q       <= dig_d;
      wd_q        <= wd_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign TxData   = tx_data_q;
  assign TxValid  = tx_valid_q;
  assign Busy     = busy_q;
  assign Finished = finished_q;
  assign TimedOut = timed_out_q;

endmodule

// File: tb/tb_result_reporter.sv
// Directed vector bench for result_reporter: three configurations share clock, reset and TxReady.
module tb_result_reporter;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [2:0]  done = '0;
  logic [2:0]  err = '0;
  logic [63:0] ans = '0;
  logic        tx_ready = 1'b1;
  logic [7:0]  txd [3];
  logic        txv [3];
  logic        busy [3];
  logic        fin [3];
  logic        tmo [3];

  always #4 Clk = ~Clk;

  result_reporter #(.ANSWER_W(16), .DIGITS(5), .DAY_ID(1), .TIMEOUT_CYCLES(100)) u_a (
    .Clk(Clk), .Rst_n(Rst_n), .Done(done[0]), .Error(err[0]), .Answer(ans[15:0]),
    .TxData(txd[0]), .TxValid(txv[0]), .TxReady(tx_ready),
    .Busy(busy[0]), .Finished(fin[0]), .TimedOut(tmo[0]));

  result_reporter #(.ANSWER_W(64), .DIGITS(20), .DAY_ID(1), .TIMEOUT_CYCLES(1000)) u_b (
    .Clk(Clk), .Rst_n(Rst_n), .Done(done[1]), .Error(err[1]), .Answer(ans),
    .TxData(txd[1]), .TxValid(txv[1]), .TxReady(tx_ready),
    .Busy(busy[1]), .Finished(fin[1]), .TimedOut(tmo[1]));

  result_reporter #(.ANSWER_W(16), .DIGITS(5), .DAY_ID(4), .TIMEOUT_CYCLES(100)) u_c (
    .Clk(Clk), .Rst_n(Rst_n), .Done(done[2]), .Error(err[2]), .Answer(ans[15:0]),
    .TxData(txd[2]), .TxValid(txv[2]), .TxReady(tx_ready),
    .Busy(busy[2]), .Finished(fin[2]), .TimedOut(tmo[2]));

  // trig: 0 = no trigger (timeout), 1 = Done, 2 = Done and Error together
  typedef struct {
    int          inst;
    int          trig;
    logic [63:0] ans;
    bit          rnd;
    int          first_edge;
    bit          exp_to;
    logic [255:0] exp;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int str_len(input logic [255:0] x);
    int n = 0;
    for (int i = 0; i < 32; i++) if (x[8*i +: 8] != 8'd0) n = i + 1;
    return n;
  endfunction

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic apply_reset();
    done = '0;
    err = '0;
    tx_ready = 1'b1;
    @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic run_vec(input int idx, input bit do_reset);
    vec_t v;
    int s, e, first, nb, len, trig_edge, last_e;
    logic [255:0] got;
    bit pv, pr, stable_ok;
    logic [7:0] pd;
    v = vecs[idx];
    s = v.inst;
    if (do_reset) begin
      apply_reset();
      check($sformatf("v%0d_reset_out", idx),
            256'({txd[s], txv[s], busy[s], fin[s], tmo[s]}), 256'(0));
    end
    ans = v.ans;
    tx_ready = 1'b1;
    e = 0; first = -1; nb = 0; got = '0; pv = 1'b0; pr = 1'b1; pd = '0;
    stable_ok = 1'b1; last_e = 0;
    len = str_len(v.exp);
    trig_edge = (v.trig == 0) ? 99 : 10;
    while (!fin[s] && e < 400) begin
      @(posedge Clk);
      e++;
      #1;
      if (pv && pr) begin
        got = {got[247:0], pd};
        nb++;
      end
      if (pv && !pr && (!txv[s] || txd[s] !== pd)) stable_ok = 1'b0;
      if (txv[s] && first < 0) first = e;
      if (e == trig_edge - 1) check($sformatf("v%0d_busy_pre", idx), 256'(busy[s]), 256'(0));
      if (e == trig_edge)     check($sformatf("v%0d_busy_trig", idx), 256'(busy[s]), 256'(1));
      if (v.exp_to && e == 98) check($sformatf("v%0d_to_pre", idx), 256'(tmo[s]), 256'(0));
      if (v.exp_to && e == 99) check($sformatf("v%0d_to_fire", idx), 256'(tmo[s]), 256'(1));
      if (e == 9 && v.trig != 0) begin
        done[s] = 1'b1;
        if (v.trig == 2) err[s] = 1'b1;
      end
      pv = txv[s];
      pd = txd[s];
      pr = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tx_ready = pr;
      last_e = e;
    end
    check($sformatf("v%0d_finished", idx), 256'(fin[s]), 256'(1));
    check($sformatf("v%0d_busy_end", idx), 256'(busy[s]), 256'(0));
    check($sformatf("v%0d_valid_end", idx), 256'(txv[s]), 256'(0));
    check($sformatf("v%0d_timedout", idx), 256'(tmo[s]), 256'(v.exp_to));
    check($sformatf("v%0d_nbytes", idx), 256'(nb), 256'(len));
    check($sformatf("v%0d_bytes", idx), got, v.exp);
    check($sformatf("v%0d_first_valid_edge", idx), 256'(first), 256'(v.first_edge));
    check($sformatf("v%0d_hold_stable", idx), 256'(stable_ok), 256'(1));
    if (!v.rnd) check($sformatf("v%0d_no_bubble", idx), 256'(last_e), 256'(v.first_edge + len));
    done[s] = 1'b0;
    err[s] = 1'b0;
    tx_ready = 1'b1;
  endtask

  initial begin
    vecs[0] = '{0, 1, 64'd1234, 1'b0, 27, 1'b0, 256'("D01=1234\n")};
    vecs[1] = '{0, 1, 64'd0, 1'b0, 27, 1'b0, 256'("D01=0\n")};
    vecs[2] = '{2, 1, 64'd7, 1'b0, 27, 1'b0, 256'("D04=7\n")};
    vecs[3] = '{1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 75, 1'b0, 256'("D01=18446744073709551615\n")};
    vecs[4] = '{0, 1, 64'd1234, 1'b1, 27, 1'b0, 256'("D01=1234\n")};
    vecs[5] = '{0, 2, 64'd55, 1'b0, 11, 1'b0, 256'("D01E\n")};
    vecs[6] = '{1, 1, 64'd10000000000, 1'b0, 75, 1'b0, 256'("D01=10000000000\n")};
    vecs[7] = '{0, 0, 64'd0, 1'b0, 100, 1'b1, 256'("D01T\n")};
    vecs[8] = '{0, 1, 64'd65535, 1'b0, 27, 1'b0, 256'("D01=65535\n")};

    for (int i = 0; i < NV; i++) run_vec(i, 1'b1);

    // Reset pulsed in the middle of a frame, then a fresh Done must give a full line
    apply_reset();
    ans = 64'd1234;
    for (int e = 1; e <= 29; e++) begin
      @(posedge Clk);
      #1;
      if (e == 9) done[0] = 1'b1;
    end
    check("midreset_busy_before", 256'(busy[0]), 256'(1));
    check("midreset_valid_before", 256'(txv[0]), 256'(1));
    Rst_n = 1'b0;
    #1;
    check("midreset_outputs", 256'({txd[0], txv[0], busy[0], fin[0], tmo[0]}), 256'(0));
    done[0] = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    run_vec(0, 1'b0);

    // Error rising after Done has been taken must not change the frame
    apply_reset();
    ans = 64'd42;
    for (int e = 1; e <= 40; e++) begin
      @(posedge Clk);
      #1;
      if (e == 9) done[0] = 1'b1;
      if (e == 12) err[0] = 1'b1;
    end
    check("late_error_finished", 256'(fin[0]), 256'(1));
    check("late_error_timedout", 256'(tmo[0]), 256'(0));
    done[0] = 1'b0;
    err[0] = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
